// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared stage indices, default geometry and NOP encoding for the MIPS pipeline registers
package mips_pipe_pkg;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MEM = 3;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_WIDTH = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/pipe_stage_cell.sv
// pipe_stage_cell: one pipeline stage (payload + valid) with clear/load/hold; PIPE_STAGE_REG_BUBBLE_ZERO_EN makes clear also zero the payload to RST_VAL
module pipe_stage_cell import mips_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= RST_VAL;
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
`ifdef PIPE_STAGE_REG_BUBBLE_ZERO_EN
      q <= RST_VAL;
`endif
    end else if (load) begin
      q <= d;
      valid <= d_valid;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage valid-tagged pipeline register with stall propagation, flush and bubble insertion (PIPE_STAGE_REG_BUBBLE_ZERO_EN selects payload zeroing on bubbles)
module pipe_stage_reg import mips_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [WIDTH-1:0]       q,
  output logic                   out_valid,
  output logic [DEPTH*WIDTH-1:0] q_flat,
  output logic [DEPTH-1:0]       stage_valid,
  output logic                   busy
);
  logic [DEPTH-1:0] stall_eff;
  logic [WIDTH-1:0] pay [DEPTH];
  logic [DEPTH-1:0] vld;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic [WIDTH-1:0] src;
    logic src_v, bub;
    assign stall_eff[i] = |(stall >> i);
    if (i == 0) begin : g_head
      assign src = d;
      assign src_v = in_valid;
      assign bub = 1'b0;
    end else begin : g_body
      assign src = pay[i-1];
      assign src_v = vld[i-1];
      assign bub = stall_eff[i-1];
    end
    // a stage that is not itself held but sits below a held one drains as a bubble
    pipe_stage_cell #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_cell (
      .clk(clk),
      .rst(rst),
      .load(~stall_eff[i]),
      .clr(flush[i] | (bub & ~stall_eff[i])),
      .d(src),
      .d_valid(src_v),
      .q(pay[i]),
      .valid(vld[i])
    );
    assign q_flat[i*WIDTH +: WIDTH] = pay[i];
  end
  assign in_ready = ~stall_eff[0];
  assign q = pay[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
  assign stage_valid = vld;
  assign busy = |vld;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (DEPTH=4, WIDTH=32)
module tb_pipe_stage_reg;
  import mips_pipe_pkg::*;
  localparam int W = 32;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] d = '0;
  logic in_valid = 1'b0;
  logic [D-1:0] stall = '0;
  logic [D-1:0] flush = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] q;
  logic [D*W-1:0] q_flat;
  logic [D-1:0] stage_valid;
  int total = 0;
  int passed = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.WIDTH(W), .DEPTH(D), .RST_VAL(NOP)) dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .q(q), .out_valid(out_valid),
    .q_flat(q_flat), .stage_valid(stage_valid), .busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] sp(input int i);
    return q_flat[i*W +: W];
  endfunction
  initial begin
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_sv", stage_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flat", q_flat, 128'h0);
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    // free flow: A0..A5 then empty inputs
    for (int n = 1; n <= 10; n++) begin
      in_valid = (n <= 6);
      d = (n <= 6) ? 32'hA0 + 32'(n - 1) : 32'h0;
      step();
      chk($sformatf("flow_ov%0d", n), out_valid, (n >= 4 && n <= 9));
      if (n >= 4 && n <= 9) chk($sformatf("flow_q%0d", n), q, 32'hA0 + 32'(n - 4));
    end
    chk("flow_busy_drained", busy, 1'b0);
    // reset mid-stream
    in_valid = 1'b1;
    d = 32'h11; step();
    d = 32'h22; step();
    d = 32'h33; step();
    chk("mid_sv", stage_valid, 4'b0111);
    chk("mid_s2", sp(2), 32'h11);
    #2 rst = 1'b1;
    #1;
    chk("arst_sv", stage_valid, 4'b0000);
    chk("arst_q", q, 32'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_flat", q_flat, 128'h0);
    rst = 1'b0;
    // stall stage 1 for two cycles
    d = 32'hB0; step();
    d = 32'hB1; step();
    d = 32'hB2; step();
    d = 32'hB3;
    stall = 4'b0010;
    #1 chk("st1_in_ready", in_ready, 1'b0);
    step();
    chk("st1_sv_a", stage_valid, 4'b1011);
    chk("st1_q_a", q, 32'hB0);
    chk("st1_s0_a", sp(0), 32'hB2);
    chk("st1_s1_a", sp(1), 32'hB1);
    step();
    chk("st1_sv_b", stage_valid, 4'b0011);
    chk("st1_s0_b", sp(0), 32'hB2);
    stall = 4'b0000;
    #1 chk("st1_ready_back", in_ready, 1'b1);
    step();
    chk("st1_sv_c", stage_valid, 4'b0111);
    chk("st1_s0_c", sp(0), 32'hB3);
    d = 32'hB4; step();
    chk("st1_q_d", q, 32'hB1);
    chk("st1_sv_d", stage_valid, 4'b1111);
    d = 32'hB5; step();
    chk("st1_q_e", q, 32'hB2);
    d = 32'hB6; step();
    chk("st1_q_f", q, 32'hB3);
    // stall stage 3 freezes everything
    stall = 4'b1000;
    #1 chk("st3_in_ready", in_ready, 1'b0);
    d = 32'hB7;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("st3_flat%0d", k), q_flat, {32'hB3, 32'hB4, 32'hB5, 32'hB6});
      chk($sformatf("st3_ov%0d", k), out_valid, 1'b1);
    end
    stall = 4'b0000;
    step();
    chk("st3_release_q", q, 32'hB4);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    // flush stage 1 together with stall stage 1
    d = 32'hC0; step();
    d = 32'hC1; step();
    d = 32'hC2; step();
    d = 32'hC3;
    stall = 4'b0010;
    flush = 4'b0010;
    step();
    chk("fl_sv", stage_valid, 4'b1001);
    chk("fl_s0", sp(0), 32'hC2);
    chk("fl_q", q, 32'hC0);
`ifdef PIPE_STAGE_REG_BUBBLE_ZERO_EN
    chk("fl_s1_zero", sp(1), 32'h0);
    chk("fl_s2_zero", sp(2), 32'h0);
`endif
    stall = 4'b0000;
    flush = 4'b0000;
    step();
    chk("fl_sv_next", stage_valid, 4'b0011);
    chk("fl_s1_next", sp(1), 32'hC2);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    // single input bubble mid-stream
    d = 32'hD0; step();
    d = 32'hD1; step();
    in_valid = 1'b0; d = 32'h0; step();
    in_valid = 1'b1; d = 32'hD2; step();
    chk("bub_sv4", stage_valid, 4'b1101);
    chk("bub_q4", q, 32'hD0);
    d = 32'hD3; step();
    chk("bub_q5", q, 32'hD1);
    in_valid = 1'b0; d = 32'h0; step();
    chk("bub_ov6", out_valid, 1'b0);
    chk("bub_q6", q, 32'h0);
    step();
    chk("bub_q7", q, 32'hD2);
    chk("bub_ov7", out_valid, 1'b1);
    step();
    chk("bub_q8", q, 32'hD3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
